chip8_mem_ctrl: RTL

Memory controller for the CHIP-8 core's single-port 4 KiB main memory. After reset it sequences the boot image: the 80-byte hex fontset at 0x000, then a streamed ROM at 0x200. It then arbitrates the one memory port between CPU instruction fetch and CPU data access, such as sprite reads, BCD writes and register store/load. It sits between `cpu`, the ROM byte source and the memory array, and replaces direct combinational memory sharing.

---
 rtl/chip8_pkg.sv | 35 +++
 rtl/chip8_mem_ctrl_rr_arb2.sv | 37 +++
 rtl/chip8_mem_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 memory subsystem.
// Fontset layout is the classic 5-row glyph table for digits 0..F.
package chip8_pkg;

  localparam int FONT_BYTES = 80;
  localparam int MEM_BYTES  = 4096;

  typedef logic [11:0] addr_t;

  typedef enum logic [1:0] {
    FONT,
    LOAD,
    RUN
  } boot_state_t;

  localparam logic [7:0] FONTSET [FONT_BYTES] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

endpackage

// File: rtl/chip8_mem_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; req[0]=data, req[1]=fetch.
// The pointer favours whichever requester was not granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       upd,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (1'b1)
        (req == 2'b11): gnt = prio_q ? 2'b10 : 2'b01;
        (req == 2'b01): gnt = 2'b01;
        (req == 2'b10): gnt = 2'b10;
        default:        gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (upd && (gnt != 2'b00)) prio_d = gnt[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/chip8_mem_ctrl.sv
// Boot sequencer (fontset, ROM stream) and single-port arbiter
// between CPU fetch and data access for the 4 KiB main memory.
module chip8_mem_ctrl
  import chip8_pkg::*;
#(
  parameter addr_t PROG_BASE = 12'h200,
  parameter int    ROM_MAX   = 3584
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  output logic       ld_ready,
  output logic       boot_done,
  output logic       boot_err,
  input  logic       if_req,
  input  logic [11:0] if_addr,
  output logic       if_gnt,
  output logic       if_rvalid,
  output logic [7:0] if_rdata,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [11:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic       d_gnt,
  output logic       d_rvalid,
  output logic [7:0] d_rdata,
  output logic       mem_en,
  output logic       mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam logic [12:0] ROM_LIM  = ROM_MAX[12:0];
  localparam logic [12:0] FONT_END = 13'(FONT_BYTES - 1);

  boot_state_t state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        rd_if_q, rd_if_d;
  logic        rd_d_q, rd_d_d;
  logic        arb_en;
  logic [1:0]  gnt;

  assign arb_en = rst_in && (state_q == RUN);

  rr_arb2 u_arb (
    .clk   (clk_in),
    .rst_n (rst_in),
    .en    (arb_en),
    .upd   (arb_en),
    .req   ({if_req, d_req}),
    .gnt   (gnt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rd_if_d   = 1'b0;
    rd_d_d    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ld_ready  = 1'b0;
    boot_done = 1'b0;
    unique case (state_q)
      FONT: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cnt_q[11:0];
        mem_wdata = FONTSET[cnt_q[6:0]];
        if (cnt_q == FONT_END) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          // Overflow beats are still consumed so the source can drain.
          if (cnt_q < ROM_LIM) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = PROG_BASE + cnt_q[11:0];
            mem_wdata = ld_data;
            cnt_d     = cnt_q + 13'd1;
          end else begin
            err_d = 1'b1;
          end
          if (ld_last) state_d = RUN;
        end
      end
      RUN: begin
        boot_done = 1'b1;
        if (gnt[1]) begin
          mem_en   = 1'b1;
          mem_addr = if_addr;
          rd_if_d  = 1'b1;
        end else if (gnt[0]) begin
          mem_en    = 1'b1;
          mem_we    = d_we;
          mem_addr  = d_addr;
          mem_wdata = d_we ? d_wdata : 8'h00;
          rd_d_d    = !d_we;
        end
      end
      default: state_d = FONT;
    endcase
    if (!rst_in) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      ld_ready  = 1'b0;
      boot_done = 1'b0;
      rd_if_d   = 1'b0;
      rd_d_d    = 1'b0;
    end
  end

  assign boot_err  = rst_in && err_q;
  assign if_gnt    = gnt[1];
  assign d_gnt     = gnt[0];
  assign if_rvalid = rst_in && rd_if_q;
  assign d_rvalid  = rst_in && rd_d_q;
  assign if_rdata  = if_rvalid ? mem_rdata : 8'h00;
  assign d_rdata   = d_rvalid ? mem_rdata : 8'h00;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= FONT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rd_if_q <= 1'b0;
      rd_d_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd_if_q <= rd_if_d;
      rd_d_q  <= rd_d_d;
    end
  end

endmodule
